score_bar_multi: RTL and testbench

Next-generation player score unit for the quiz-game board. It takes N_PLAYERS raw active-low buttons and, per player:
- synchronises and debounces the button;
- counts one point per press;
- drives a thermometer LED bar.
It also detects the first player to reach WIN_SCORE and freezes scoring until the round is cleared. It replaces the per-player unclocked counters with one clocked, parametrised block.

---
 rtl/score_bar_multi.sv | 102 ++++++++++
 tb/tb_score_bar_multi.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/score_bar_multi.sv
// score_bar_multi: per-player button debounce, point counting, LED bar and first-to-win latch
// Ports:
//   clk, rst_n      - rising-edge clock, asynchronous active-low reset
//   btn_n           - raw active-low player buttons, asynchronous to clk
//   enable          - presses counted when 1, dropped when 0
//   clear           - synchronous round clear (scores and winner)
//   score           - per-player score, player i at [i*SCORE_W +: SCORE_W]
//   led_bar         - per-player thermometer bar, player i at [i*LED_W +: LED_W]
//   win_valid       - a winner has been latched; scoring is frozen
//   winner_id       - index of the latched winner
module score_bar_multi #(
  parameter int N_PLAYERS  = 2,
  parameter int ID_W       = 2,
  parameter int SCORE_W    = 4,
  parameter int MAX_SCORE  = 10,
  parameter int WIN_SCORE  = 5,
  parameter int LED_W      = 5,
  parameter int DEB_CYCLES = 4,
  parameter bit WRAP_MODE  = 1'b1
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [N_PLAYERS-1:0]         btn_n,
  input  logic                         enable,
  input  logic                         clear,
  output logic [N_PLAYERS*SCORE_W-1:0] score,
  output logic [N_PLAYERS*LED_W-1:0]   led_bar,
  output logic                         win_valid,
  output logic [ID_W-1:0]              winner_id
);
  localparam int CW = $clog2(DEB_CYCLES + 1);
  logic [N_PLAYERS-1:0] sync1_q, sync2_q, stable_q, stable_d, press_q, press_d;
  logic [CW-1:0]        cnt_q [N_PLAYERS];
  logic [CW-1:0]        cnt_d [N_PLAYERS];
  logic [SCORE_W-1:0]   score_q [N_PLAYERS];
  logic [SCORE_W-1:0]   score_d [N_PLAYERS];
  logic [SCORE_W-1:0]   nxt [N_PLAYERS];
  logic                 win_q, win_d;
  logic [ID_W-1:0]      id_q, id_d;
  // Debounce: stable follows sync2 on the DEB_CYCLES-th consecutive mismatching cycle,
  // and the press pulse is registered on that same edge so it lines up with stable.
  always_comb begin
    for (int i = 0; i < N_PLAYERS; i++) begin
      stable_d[i] = stable_q[i];
      cnt_d[i]    = '0;
      if (sync2_q[i] != stable_q[i]) begin
        stable_d[i] = (cnt_q[i] == CW'(DEB_CYCLES - 1)) ? sync2_q[i] : stable_q[i];
        cnt_d[i]    = (cnt_q[i] == CW'(DEB_CYCLES - 1)) ? '0 : cnt_q[i] + 1'b1;
      end
      press_d[i] = stable_q[i] & ~stable_d[i];
    end
  end
  // Descending scan so the lowest index reaching WIN_SCORE is the one latched.
  always_comb begin
    win_d = win_q;
    id_d  = id_q;
    for (int i = N_PLAYERS - 1; i >= 0; i--) begin
      nxt[i] = (score_q[i] == SCORE_W'(MAX_SCORE)) ? (WRAP_MODE ? '0 : score_q[i]) : score_q[i] + 1'b1;
      score_d[i] = (press_q[i] && enable && !win_q) ? nxt[i] : score_q[i];
      if (press_q[i] && enable && !win_q && WIN_SCORE != 0 && nxt[i] == SCORE_W'(WIN_SCORE)) begin
        win_d = 1'b1;
        id_d  = ID_W'(i);
      end
      score_d[i] = clear ? '0 : score_d[i];
    end
    win_d = clear ? 1'b0 : win_d;
    id_d  = clear ? '0 : id_d;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q  <= '1;
      sync2_q  <= '1;
      stable_q <= '1;
      press_q  <= '0;
      win_q    <= 1'b0;
      id_q     <= '0;
      for (int i = 0; i < N_PLAYERS; i++) begin
        cnt_q[i]   <= '0;
        score_q[i] <= '0;
      end
    end else begin
      sync1_q  <= btn_n;
      sync2_q  <= sync1_q;
      stable_q <= stable_d;
      press_q  <= press_d;
      win_q    <= win_d;
      id_q     <= id_d;
      for (int i = 0; i < N_PLAYERS; i++) begin
        cnt_q[i]   <= cnt_d[i];
        score_q[i] <= score_d[i];
      end
    end
  end
  for (genvar g = 0; g < N_PLAYERS; g++) begin : g_out
    assign score[g*SCORE_W +: SCORE_W] = score_q[g];
    for (genvar j = 0; j < LED_W; j++) begin : g_led
      assign led_bar[g*LED_W + j] = 32'(score_q[g]) > j;
    end
  end
  assign win_valid = win_q;
  assign winner_id = id_q;
endmodule

// File: tb/tb_score_bar_multi.sv
// tb_score_bar_multi: directed table-driven bench for score_bar_multi across four configurations
module tb_score_bar_multi;
  logic        clk, rst_n, enable, clear;
  logic [8:0]  btn;
  logic [7:0]  sc0, sc1, sc2;
  logic [11:0] sc3;
  logic [9:0]  led0, led1, led2;
  logic [14:0] led3;
  logic        wv0, wv1, wv2, wv3;
  logic [1:0]  wid0, wid1, wid2, wid3;
  int          checks = 0;
  int          failures = 0;
  typedef struct {
    logic [8:0] m;
    int         lo;
    logic [3:0] s0, s1;
    logic       wv;
    logic [1:0] wid;
  } vec_t;
  vec_t tbl [8];
  score_bar_multi u0 (.clk(clk), .rst_n(rst_n), .btn_n(btn[1:0]), .enable(enable), .clear(clear),
    .score(sc0), .led_bar(led0), .win_valid(wv0), .winner_id(wid0));
  score_bar_multi #(.WIN_SCORE(0), .WRAP_MODE(1'b1)) u1 (.clk(clk), .rst_n(rst_n), .btn_n(btn[3:2]),
    .enable(enable), .clear(clear), .score(sc1), .led_bar(led1), .win_valid(wv1), .winner_id(wid1));
  score_bar_multi #(.WIN_SCORE(0), .WRAP_MODE(1'b0)) u2 (.clk(clk), .rst_n(rst_n), .btn_n(btn[5:4]),
    .enable(enable), .clear(clear), .score(sc2), .led_bar(led2), .win_valid(wv2), .winner_id(wid2));
  score_bar_multi #(.N_PLAYERS(3)) u3 (.clk(clk), .rst_n(rst_n), .btn_n(btn[8:6]), .enable(enable),
    .clear(clear), .score(sc3), .led_bar(led3), .win_valid(wv3), .winner_id(wid3));
  initial clk = 1'b0;
  always #5 clk = ~clk;
  function automatic logic [4:0] therm(input logic [3:0] s);
    return (s >= 4'd5) ? 5'h1f : 5'((1 << s) - 1);
  endfunction
  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", n, a, e);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic press(input logic [8:0] m, input int lo, input int hi);
    btn = btn & ~m;
    repeat (lo) tick();
    btn = btn | m;
    repeat (hi) tick();
  endtask
  task automatic do_reset();
    rst_n = 1'b0;
    btn = '1;
    enable = 1'b1;
    clear = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
  endtask
  initial begin
    tbl[0] = '{9'b01_0, 3, 4'd1, 4'd0, 1'b0, 2'd0};
    tbl[1] = '{9'b10, 1, 4'd1, 4'd0, 1'b0, 2'd0};
    tbl[2] = '{9'b10, 8, 4'd1, 4'd1, 1'b0, 2'd0};
    tbl[3] = '{9'b10, 6, 4'd1, 4'd2, 1'b0, 2'd0};
    tbl[4] = '{9'b10, 6, 4'd1, 4'd3, 1'b0, 2'd0};
    tbl[5] = '{9'b10, 6, 4'd1, 4'd4, 1'b0, 2'd0};
    tbl[6] = '{9'b10, 6, 4'd1, 4'd5, 1'b1, 2'd1};
    tbl[7] = '{9'b01, 6, 4'd1, 4'd5, 1'b1, 2'd1};
    tbl[0].m = 9'b10;
    do_reset();
    chk("reset score", 32'(sc0), 32'd0);
    chk("reset led", 32'(led0), 32'd0);
    chk("reset win", 32'({wv0, wid0}), 32'd0);
    btn[0] = 1'b0;
    repeat (6) tick();
    chk("latency before", 32'(sc0), 32'd0);
    tick();
    chk("latency at", 32'(sc0), 32'd1);
    chk("latency led", 32'(led0), 32'h001);
    repeat (3) tick();
    btn[0] = 1'b1;
    repeat (8) tick();
    chk("single press", 32'(sc0), 32'd1);
    for (int r = 0; r < 8; r++) begin
      press(tbl[r].m, tbl[r].lo, 8);
      chk($sformatf("row%0d score", r), 32'(sc0), 32'({tbl[r].s1, tbl[r].s0}));
      chk($sformatf("row%0d led", r), 32'(led0), 32'({therm(tbl[r].s1), therm(tbl[r].s0)}));
      chk($sformatf("row%0d win_valid", r), 32'(wv0), 32'(tbl[r].wv));
      chk($sformatf("row%0d winner_id", r), 32'(wid0), 32'(tbl[r].wid));
    end
    clear = 1'b1;
    tick();
    clear = 1'b0;
    chk("clear score", 32'(sc0), 32'd0);
    chk("clear win", 32'({wv0, wid0}), 32'd0);
    do_reset();
    for (int i = 1; i <= 11; i++) begin
      press(9'b01_0100, 6, 8);
      chk($sformatf("wrap press%0d", i), 32'(sc1[3:0]), (i == 11) ? 32'd0 : 32'(i));
      chk($sformatf("sat press%0d", i), 32'(sc2[3:0]), (i > 10) ? 32'd10 : 32'(i));
    end
    chk("wrap no win", 32'(wv1), 32'd0);
    chk("sat led full", 32'(led2[4:0]), 32'h1f);
    chk("sat no win", 32'(wv2), 32'd0);
    do_reset();
    for (int i = 1; i <= 4; i++) press(9'b101_000000, 6, 8);
    chk("tie pre score", 32'(sc3), 32'({4'd4, 4'd0, 4'd4}));
    chk("tie pre win", 32'(wv3), 32'd0);
    press(9'b101_000000, 6, 8);
    chk("tie score", 32'(sc3), 32'({4'd5, 4'd0, 4'd5}));
    chk("tie win", 32'({wv3, wid3}), 32'({1'b1, 2'd0}));
    chk("tie led", 32'(led3), 32'({5'h1f, 5'h00, 5'h1f}));
    clear = 1'b1;
    tick();
    clear = 1'b0;
    btn[7] = 1'b0;
    repeat (6) tick();
    clear = 1'b1;
    tick();
    clear = 1'b0;
    chk("press on clear", 32'(sc3), 32'd0);
    repeat (10) tick();
    chk("held through clear", 32'(sc3), 32'd0);
    btn[7] = 1'b1;
    repeat (8) tick();
    enable = 1'b0;
    press(9'b010_000000, 6, 8);
    enable = 1'b1;
    chk("enable off", 32'(sc3), 32'd0);
    press(9'b010_000000, 6, 8);
    chk("enable on", 32'(sc3), 32'({4'd0, 4'd1, 4'd0}));
    do_reset();
    press(9'b01, 6, 8);
    chk("pre async", 32'(sc0), 32'd1);
    btn[0] = 1'b0;
    repeat (3) tick();
    rst_n = 1'b0;
    #2;
    chk("async score", 32'(sc0), 32'd0);
    chk("async led", 32'(led0), 32'd0);
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (6) tick();
    chk("post reset before", 32'(sc0), 32'd0);
    tick();
    chk("post reset at", 32'(sc0), 32'd1);
    repeat (10) tick();
    chk("post reset once", 32'(sc0), 32'd1);
    btn[0] = 1'b1;
    repeat (8) tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
